data_mem: RTL and testbench

- Word-organised data memory for the single-cycle MIPS datapath; serves load/store instructions from the MEM stage.
- Writes are synchronous on the clock edge.
- Reads are combinational, so a load completes in the same cycle.
- A synchronous reset clears the whole array.

---
 rtl/data_mem.sv | 45 ++++
 tb/tb_data_mem.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// ============================================================================
//  Module      : data_mem
//  Description : Word-organised data memory for the single-cycle MIPS MEM stage.
//                Synchronous write, combinational read, synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        r,
  input  logic        w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rst
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_unused_addr_bits;

  // Byte-offset and upper address bits are dropped: forced alignment and aliasing.
  assign w_idx              = addr[AW+1:2];
  assign w_unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w) begin
      r_mem[w_idx] <= wdata;
    end
  end

  // No write bypass: a same-index read shows the new word only after the edge.
  assign rdata = r ? r_mem[w_idx] : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem.sv
// ============================================================================
//  Module      : tb_data_mem
//  Description : Self-checking bench for data_mem: vector table, sweep, random.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r   = 1'b0;
  logic        w   = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [DEPTH];

  data_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .r    (r),
    .w    (w),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .rst  (rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // rdata expected before the edge
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(string n, logic rs, logic rd, logic wr,
                              logic [31:0] a, logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.name = n; v.rst = rs; v.r = rd; v.w = wr; v.addr = a; v.wdata = d; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: rdata=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rs, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    rst = rs; r = rd; w = wr; addr = a; wdata = d;
    #1;
  endtask

  // Reference: word index is the byte address divided by four, modulo DEPTH.
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
    return rd ? model[widx(a)] : 32'h0;
  endfunction

  task automatic edge_and_update();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    end else if (w) begin
      model[widx(addr)] = wdata;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("store9_a",      0, 0, 1, 32'd2,    32'd9,          32'h0);
    vecs[1]  = mk("store9_b",      0, 0, 1, 32'd2,    32'd9,          32'h0);
    vecs[2]  = mk("load_addr2",    0, 1, 0, 32'd2,    32'h0,          32'd9);
    vecs[3]  = mk("load_addr0",    0, 1, 0, 32'd0,    32'h0,          32'd9);
    vecs[4]  = mk("r0_zero",       0, 0, 0, 32'd0,    32'h0,          32'h0);
    vecs[5]  = mk("store_beef",    0, 1, 1, 32'd4,    32'hDEADBEEF,   32'h0);
    vecs[6]  = mk("alias_1028",    0, 1, 0, 32'd1028, 32'h0,          32'hDEADBEEF);
    vecs[7]  = mk("addr8_zero",    0, 1, 0, 32'd8,    32'h0,          32'h0);
    vecs[8]  = mk("store5_idx3",   0, 0, 1, 32'd12,   32'd5,          32'h0);
    vecs[9]  = mk("rdw_before",    0, 1, 1, 32'd12,   32'd7,          32'd5);
    vecs[10] = mk("rdw_after",     0, 1, 0, 32'd12,   32'h0,          32'd7);
    vecs[11] = mk("rst_old_data",  1, 1, 0, 32'd12,   32'h0,          32'd7);
    vecs[12] = mk("rst_cleared",   0, 1, 0, 32'd12,   32'h0,          32'h0);
    vecs[13] = mk("refill_idx1",   0, 0, 1, 32'd4,    32'h1234_5678,  32'h0);
    vecs[14] = mk("rst_prio",      1, 1, 1, 32'd16,   32'd1,          32'h0);
    vecs[15] = mk("rst_prio_16",   0, 1, 0, 32'd16,   32'h0,          32'h0);
    vecs[16] = mk("rst_prio_4",    0, 1, 0, 32'd4,    32'h0,          32'h0);

    // Initial reset, then reads across the address range.
    @(posedge clk); #1;
    drive(1, 0, 0, 32'h0, 32'h0);
    edge_and_update();
    drive(0, 1, 0, 32'd0, 32'h0);    check("reset_rd_0",    rdata, 32'h0);
    drive(0, 1, 0, 32'd4, 32'h0);    check("reset_rd_4",    rdata, 32'h0);
    drive(0, 1, 0, 32'd1020, 32'h0); check("reset_rd_1020", rdata, 32'h0);

    // Directed vector table; each row is checked before its clock edge.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata);
      check(vecs[i].name, rdata, vecs[i].exp);
      edge_and_update();
    end

    // Full sweep with garbage in offset/upper bits, read back without clocks.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, (32'($urandom) & ~32'h3FC) | (32'(i) << 2), 32'(i * 3));
      edge_and_update();
    end
    drive(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 32'(i) << 2, 32'h0);
      check("sweep_rd", rdata, 32'(i * 3));
    end

    // Randomised traffic against the reference array; small address window for collisions.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ((32'($urandom) & 32'hFFFF_F000) | 32'($urandom_range(0, 63)));
      drive(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), a, 32'($urandom));
      check("rand_rd", rdata, model_read(r, addr));
      a = 32'($urandom);
      addr = a;
      #1;
      check("rand_addr_change", rdata, model_read(r, addr));
      edge_and_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
